// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
// Size and state encodings plus the latched request bundle.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    size_e       size;
    logic        uns;
  } req_t;

  function automatic logic [31:0] ext8(
    input logic [7:0] b,
    input logic       uns
  );
    return {{24{~uns & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(
    input logic [15:0] h,
    input logic        uns
  );
    return {{16{~uns & h[15]}}, h};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for one access: store lane enables and
// read-modify-write merge, load extract/extend, misalignment.
// Ports:
//   addr_lo_i  byte offset within the word
//   size_i     access size
//   uns_i      zero-extend loads when 1
//   wdata_i    right-aligned store data
//   rword_i    current contents of the addressed word
//   bad_o      misaligned or illegal size
//   be_o       lanes written by a store
//   wword_o    full word to write back
//   rdata_o    right-aligned, extended load data
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  size_e       size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic        bad_o,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rep;
  logic [31:0] shifted;

  always_comb begin
    bad_o   = 1'b0;
    be_o    = 4'b0000;
    rep     = wdata_i;
    rdata_o = '0;
    shifted = rword_i >> {addr_lo_i, 3'b000};
    unique case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        rep     = {4{wdata_i[7:0]}};
        rdata_o = ext8(shifted[7:0], uns_i);
      end
      SZ_HALF: begin
        bad_o   = addr_lo_i[0];
        be_o    = addr_lo_i[1] ? 4'b1100
                               : 4'b0011;
        rep     = {2{wdata_i[15:0]}};
        rdata_o = addr_lo_i[1]
                ? ext16(rword_i[31:16], uns_i)
                : ext16(rword_i[15:0], uns_i);
      end
      SZ_WORD: begin
        bad_o   = |addr_lo_i;
        be_o    = 4'b1111;
        rdata_o = rword_i;
      end
      default: begin
        bad_o = 1'b1;
      end
    endcase
  end

  // Unselected lanes keep the old bytes so the
  // whole word can be written back in one go.
  always_comb begin
    wword_o = rword_i;
    for (int i = 0; i < 4; i++) begin
      if (be_o[i]) begin
        wword_o[8*i +: 8] = rep[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with optional
// wait states (macro DMEM_WAIT_EN enables WAIT_CYCLES).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   request handshake
//   req_we/addr/wdata request fields (store data right-aligned)
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned      load zero-extends when 1
//   rsp_valid/ready   response handshake
//   rsp_rdata         load data, 0 for stores and errors
//   rsp_err           misaligned, out of range or bad size
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e state_q, state_d;
  req_t   req_q, cur;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic          accept;
  logic          in_range;
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic          bad;
  logic [3:0]    be;
  logic [31:0]   wword;
  logic [31:0]   ld;
  logic          err;
  logic          enter_resp;
  logic          commit;
  logic          use_wait;
  logic          wait_done;

`ifdef DMEM_WAIT_EN
  logic [3:0] cnt_q, cnt_d;

  assign use_wait  = (WAIT_CYCLES > 0);
  assign wait_done = (cnt_q == 4'(WAIT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    if (state_q == WAIT) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign use_wait  = 1'b0;
  // WAIT is unreachable here; leave it at once.
  assign wait_done = 1'b1;
`endif

  assign accept = req_valid & req_ready;

  // On the accepting cycle the live request is used so
  // the zero-wait path can commit on the very next edge.
  always_comb begin
    cur = req_q;
    if (state_q == IDLE) begin
      cur = '{we:    req_we,
              addr:  req_addr,
              wdata: req_wdata,
              size:  size_e'(req_size),
              uns:   req_unsigned};
    end
  end

  assign in_range =
    ({2'b00, cur.addr[31:2]} < 32'(DEPTH_WORDS));
  assign widx  = cur.addr[AW+1:2];
  assign rword = in_range ? mem_q[widx] : '0;

  dmem_lane_align u_align (
    .addr_lo_i (cur.addr[1:0]),
    .size_i    (cur.size),
    .uns_i     (cur.uns),
    .wdata_i   (cur.wdata),
    .rword_i   (rword),
    .bad_o     (bad),
    .be_o      (be),
    .wword_o   (wword),
    .rdata_o   (ld)
  );

  assign err = bad | ~in_range;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = use_wait ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (wait_done) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  assign enter_resp = (state_d == RESP) &&
                      (state_q != RESP) && !rst;
  assign commit = enter_resp & cur.we & ~err;

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      rdata_d = (err | cur.we) ? '0 : ld;
      err_d   = err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q <= cur;
      end
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[widx] <= wword;
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit storage words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states per access when DMEM_WAIT_EN is defined; legal range 0..15.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-011 SHALL have port req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  initiator takes the response.
REQ-014 SHALL have port rsp_rdata  output  32  load data, right-aligned and extended; 0 for stores and errors.
REQ-015 SHALL have port rsp_err  output  1  access was misaligned, out of range or illegal size.

Function
REQ-016 SHALL implement the states IDLE, WAIT and RESP, with one transaction outstanding at a time.
REQ-017 SHALL drive req_ready = 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1, and all req_* fields are latched on that cycle.
REQ-018 SHALL transition on acceptance from IDLE to WAIT when DMEM_WAIT_EN is defined and WAIT_CYCLES > 0, and otherwise directly to RESP.
REQ-019 SHALL count exactly WAIT_CYCLES cycles in WAIT before entering RESP.
REQ-020 SHALL commit the store, or capture the load data, on the clock edge that enters RESP.
REQ-021 SHALL give rsp_valid as a function of acceptance cycle T: rsp_valid = 1 at T+1 without wait states, or at T+1+WAIT_CYCLES with them.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1.
REQ-023 SHALL return from RESP to IDLE on the rsp_ready handshake; req_ready rises the following cycle, and req_ready and rsp_valid are never both 1.
REQ-024 SHALL select byte lanes as follows: byte at lane addr[1:0]; half at lanes {addr[1],0}; word uses all four lanes. A store writes only the addressed lanes.
REQ-025 SHALL set rsp_err = 1 when any of these holds: half with addr[0] = 1; word with addr[1:0] != 0; size = 11; addr[31:2] >= DEPTH_WORDS. On error the store is not written and rsp_rdata = 0.
REQ-026 SHALL, for loads of byte and half, extend bit 7 or bit 15 respectively according to req_unsigned; word loads are unmodified.
REQ-027 SHALL keep the storage array uninitialised by reset; contents persist across reset.

Reset
REQ-028 SHALL, on rst = 1 at a clock edge, set the state to IDLE, the wait counter to 0, rsp_valid to 0, rsp_rdata to 0 and rsp_err to 0.
REQ-029 SHALL give req_ready = 1 on the first cycle after rst deasserts.
REQ-030 SHALL drop an in-flight transaction in WAIT when reset hits; its store is not committed.
REQ-031 SHALL leave a store already committed on RESP entry written when reset follows.

Configuration
REQ-032 SHALL, with macro DMEM_WAIT_EN defined, insert WAIT_CYCLES wait states per REQ-018/019.
REQ-033 SHALL, with DMEM_WAIT_EN undefined, remove the WAIT state and counter; latency is fixed at 1 cycle and WAIT_CYCLES is ignored.

Structure
REQ-034 SHALL take the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the state encodings (IDLE, WAIT, RESP) from the shared package dmem_pkg.
REQ-035 SHALL place lane logic in one combinational sub-module dmem_lane_align: store lane-enable/data-merge, load extract/extend and misalignment detection.

Verification
REQ-036 SHALL verify word store/load: store 0xDEADBEEF at 0x10, then load word from 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0, latency 1 (no macro) or 3 (macro, WAIT_CYCLES = 2).
REQ-037 SHALL verify byte extension: after REQ-036, load byte at 0x13, signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half at 0x12, signed -> 0xFFFFDEAD.
REQ-038 SHALL verify a partial store: store byte 0x55 at 0x11, then load word from 0x10 -> 0xDEAD55EF.
REQ-039 SHALL verify errors: half load at 0x11 -> rsp_err = 1, rdata = 0; word store 0x1 at 4*DEPTH_WORDS -> rsp_err = 1, and a reload of address 0 is unchanged.
REQ-040 SHALL verify backpressure and reset: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready = 0; assert rst during WAIT of a store to 0x20 -> no write, idle next cycle.
